// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
//   rx_state_e  - receiver FSM states
//   PAR_*       - parity mode encodings for the PARITY parameter
//   tick_div()  - rounded clock divisor for one oversample tick
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // round(clk_hz / (baud * os))
  function automatic int tick_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through FIFO.
//   clk, rst  - clock, async active-high reset
//   i_push    - write i_data (accepted when not full, or full with a pop)
//   i_pop     - read the head word (ignored while empty)
//   o_data    - head word, zero while empty
//   o_valid   - not empty
//   o_count   - occupancy 0..DEPTH
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_count;
  logic             w_pop, w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // Full FIFO still takes a push if the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a FWFT receive FIFO.
//   clk, rst     - system clock, async active-high reset
//   uart_rx      - asynchronous serial line, idle high
//   rx_data      - FIFO head word, valid while rx_valid
//   rx_valid     - FIFO not empty
//   rx_ready     - consumer pop strobe
//   fifo_count   - FIFO occupancy
//   frame_err    - pulse: a stop bit sampled low
//   parity_err   - pulse: parity mismatch
//   overrun      - pulse: good frame dropped because the FIFO was full
module uart_rx_fifo import uart_pkg::*; #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int DIV = tick_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int M   = OVERSAMPLE / 2;

  rx_state_e           r_state;
  logic [1:0]          r_sync;
  logic                r_rx_prev;
  logic [TW-1:0]       r_tick_cnt;
  logic [SW-1:0]       r_s;
  logic [1:0]          r_samp;
  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]       r_bit_idx;
  logic                r_stop_cnt;
  logic                r_stop_bad;
  logic                r_par_bad;

  logic w_rx, w_start_edge, w_tick, w_mid, w_maj;
  logic w_pop, w_full, w_final, w_stop_bad, w_push;

  assign w_rx         = r_sync[1];
  assign w_start_edge = (r_state == IDLE) && r_rx_prev && !w_rx;
  assign w_tick       = (r_tick_cnt == TW'(DIV - 1));
  // Decision point of each bit: the third of the three mid-bit samples.
  assign w_mid        = w_tick && (r_s == SW'(M + 1));
  assign w_maj        = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);
  assign w_pop        = rx_valid && rx_ready;
  assign w_full       = (fifo_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
  assign w_final      = (r_state == STOP) && w_mid && (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_stop_bad   = r_stop_bad | ~w_maj;
  assign w_push       = w_final && !w_stop_bad && !r_par_bad && (!w_full || w_pop);

  // 2-flop synchroniser; prev copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], uart_rx};
      r_rx_prev <= w_rx;
    end
  end

  // Tick generator and sample index; both realign to the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_s        <= '0;
      r_samp     <= 2'b11;
    end else begin
      if (w_start_edge || w_tick) r_tick_cnt <= '0;
      else                        r_tick_cnt <= r_tick_cnt + TW'(1);
      if (w_start_edge)      r_s <= '0;
      else if (w_tick)       r_s <= (r_s == SW'(OVERSAMPLE - 1)) ? '0 : r_s + SW'(1);
      if (w_tick && r_s == SW'(M - 1)) r_samp[0] <= w_rx;
      if (w_tick && r_s == SW'(M))     r_samp[1] <= w_rx;
    end
  end

  // State advances at each mid-bit; r_s keeps counting so the next
  // bit's mid point falls exactly one bit period later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_stop_bad <= 1'b0;
      r_par_bad  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      case (r_state)
        IDLE: if (w_start_edge) r_state <= START;
        START: begin
          r_bit_idx  <= '0;
          r_stop_cnt <= 1'b0;
          r_stop_bad <= 1'b0;
          r_par_bad  <= 1'b0;
          if (w_mid) r_state <= w_maj ? IDLE : DATA;
        end
        DATA: if (w_mid) begin
          r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == BW'(DATA_BITS - 1)) begin
            if (PARITY != PAR_NONE) r_state <= uart_pkg::PARITY;
            else                    r_state <= STOP;
          end else begin
            r_bit_idx <= r_bit_idx + BW'(1);
          end
        end
        uart_pkg::PARITY: if (w_mid) begin
          r_par_bad <= w_maj != ((^r_shift) ^ (PARITY == PAR_ODD));
          r_state   <= STOP;
        end
        STOP: if (w_mid) begin
          if (w_final) begin
            if (w_stop_bad) begin
              frame_err <= 1'b1;
              r_state   <= WAIT_IDLE;
            end else begin
              r_state <= IDLE;
              if (r_par_bad)            parity_err <= 1'b1;
              else if (w_full && !w_pop) overrun   <= 1'b1;
            end
          end else begin
            r_stop_bad <= ~w_maj;
            r_stop_cnt <= 1'b1;
          end
        end
        WAIT_IDLE: if (w_rx) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (rx_ready),
    .o_data  (rx_data),
    .o_valid (rx_valid),
    .o_count (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int CLKS_PER_BIT = 27 * 16;
  localparam int BIT = CLKS_PER_BIT * 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // default-configured DUT
  logic       line = 1'b1, rdy = 1'b0;
  logic [7:0] d0;
  logic       v0, fe0, pe0, ov0;
  logic [2:0] c0;
  // even-parity DUT
  logic       line_p = 1'b1, rdy_p = 1'b0;
  logic [7:0] d1;
  logic       v1, fe1, pe1, ov1;
  logic [2:0] c1;

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .uart_rx(line), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy),
    .fifo_count(c0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

  uart_rx_fifo #(.PARITY(1)) dut_p (
    .clk(clk), .rst(rst), .uart_rx(line_p), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy_p),
    .fifo_count(c1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

  int total = 0, bad = 0;
  int n_fe0 = 0, n_pe0 = 0, n_ov0 = 0, n_fe1 = 0, n_pe1 = 0, n_ov1 = 0;
  logic [7:0] q0[$], q1[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitors: compare every accepted pop with the queue head
  always @(negedge clk) begin
    if (fe0) n_fe0++;
    if (pe0) n_pe0++;
    if (ov0) n_ov0++;
    if (fe1) n_fe1++;
    if (pe1) n_pe1++;
    if (ov1) n_ov1++;
    if (!rst && v0 && rdy) begin
      total++;
      if (q0.size() == 0) begin
        bad++; $display("FAIL pop0_unexpected: got %0h expected none", d0);
      end else begin
        logic [7:0] e;
        e = q0.pop_front();
        if (d0 !== e) begin bad++; $display("FAIL pop0_data: got %0h expected %0h", d0, e); end
      end
    end
    if (!rst && v1 && rdy_p) begin
      total++;
      if (q1.size() == 0) begin
        bad++; $display("FAIL pop1_unexpected: got %0h expected none", d1);
      end else begin
        logic [7:0] e;
        e = q1.pop_front();
        if (d1 !== e) begin bad++; $display("FAIL pop1_data: got %0h expected %0h", d1, e); end
      end
    end
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) line_p = v; else line = v;
  endtask

  // start, 8 data bits LSB first, optional parity, stop (optionally held low)
  task automatic send(input bit sel, input logic [7:0] d, input bit use_par,
                      input logic pbit, input int stop_low);
    drive(sel, 1'b0); #(BIT);
    for (int i = 0; i < 8; i++) begin drive(sel, d[i]); #(BIT); end
    if (use_par) begin drive(sel, pbit); #(BIT); end
    if (stop_low > 0) begin drive(sel, 1'b0); #(BIT * stop_low); end
    drive(sel, 1'b1); #(BIT);
  endtask

  task automatic drain(input bit sel, input int n);
    @(posedge clk); #1;
    if (sel) rdy_p = 1'b1; else rdy = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    if (sel) rdy_p = 1'b0; else rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int fe, pe, ov;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_valid", v0, 0);
    chk("rst_data", d0, 0);
    chk("rst_count", c0, 0);
    chk("rst_pulses", {fe0, pe0, ov0}, 0);
    rst = 1'b0;
    #(BIT * 2);

    // single frame, rx_ready low
    fe = n_fe0; pe = n_pe0; ov = n_ov0;
    send(0, 8'h55, 0, 0, 0);
    q0.push_back(8'h55);
    chk("t1_valid", v0, 1);
    chk("t1_data", d0, 8'h55);
    chk("t1_count", c0, 1);
    chk("t1_no_err", (n_fe0 - fe) + (n_pe0 - pe) + (n_ov0 - ov), 0);
    drain(0, 1);
    chk("t1_empty", c0, 0);

    // three frames then exactly three pops
    send(0, 8'h55, 0, 0, 0); q0.push_back(8'h55);
    send(0, 8'hA3, 0, 0, 0); q0.push_back(8'hA3);
    send(0, 8'hFF, 0, 0, 0); q0.push_back(8'hFF);
    chk("t2_count3", c0, 3);
    drain(0, 3);
    chk("t2_valid0", v0, 0);
    chk("t2_count0", c0, 0);
    chk("t2_sb_empty", q0.size(), 0);

    // overrun on the fifth frame
    ov = n_ov0;
    for (int i = 1; i <= 5; i++) begin
      send(0, 8'(i), 0, 0, 0);
      if (i <= 4) q0.push_back(8'(i));
    end
    chk("t3_overrun", n_ov0 - ov, 1);
    chk("t3_count", c0, 4);
    drain(0, 4);
    chk("t3_drained", q0.size(), 0);

    // framing error, then recovery
    fe = n_fe0;
    send(0, 8'h3C, 0, 0, 2);
    chk("t5_frame_err", n_fe0 - fe, 1);
    chk("t5_no_push", c0, 0);
    #(BIT);
    send(0, 8'h3C, 0, 0, 0); q0.push_back(8'h3C);
    chk("t5_recover_cnt", c0, 1);
    drain(0, 1);

    // start glitch of a quarter bit
    fe = n_fe0; pe = n_pe0; ov = n_ov0;
    line = 1'b0; #(BIT / 4);
    line = 1'b1; #(BIT * 2);
    chk("t6_glitch_flags", (n_fe0 - fe) + (n_pe0 - pe) + (n_ov0 - ov), 0);
    chk("t6_glitch_count", c0, 0);

    // parity DUT: wrong then right parity bit (0xA3 has four ones -> even bit 0)
    pe = n_pe1;
    send(1, 8'hA3, 1, 1'b1, 0);
    chk("t4_parity_err", n_pe1 - pe, 1);
    chk("t4_no_push", c1, 0);
    send(1, 8'hA3, 1, 1'b0, 0); q1.push_back(8'hA3);
    chk("t4_good_cnt", c1, 1);
    chk("t4_good_data", d1, 8'hA3);
    drain(1, 1);
    chk("t4_sb_empty", q1.size(), 0);

    // reset mid-frame flushes a queued word
    send(0, 8'h11, 0, 0, 0);
    chk("t7_preload", c0, 1);
    line = 1'b0; #(BIT);
    for (int i = 0; i < 3; i++) begin line = 1'b1; #(BIT); end
    #(BIT / 2);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_rst_valid", v0, 0);
    chk("t7_rst_count", c0, 0);
    chk("t7_rst_data", d0, 0);
    q0.delete();
    rst = 1'b0;
    #(BIT * 6);
    chk("t7_post_count", c0, 0);
    send(0, 8'h5A, 0, 0, 0); q0.push_back(8'h5A);
    chk("t7_5a_data", d0, 8'h5A);
    drain(0, 1);
    chk("final_sb0", q0.size(), 0);
    chk("final_p_err", n_fe1 + n_ov1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit
  initial begin
    #(BIT * 200);
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
